mux8_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 datapath multiplexer, and the single resource behind it (e.g. memory port or ALU input), among 8 requesters.
- Grants exactly one requester at a time and drives the mux select with that requester's index.
- Holds the grant until the resource signals transaction completion.
- Sits between the multicycle control logic / requesters and the `MUX_8_1` select input.

---
 rtl/mux8_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mux8_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_port_arbiter.sv
// mux8_port_arbiter: round-robin arbiter for eight requesters that share one
// 8:1 datapath mux and the single resource behind it.
//
// Optional watchdog: define ARB_TIMEOUT_EN to force-release a grant that has
// been held for TO_LIMIT BUSY cycles without a done strobe.
//
// Handshake contract: req[i] is a level request. The requester owns the
// resource from the cycle grant[i] is seen high until the resource returns
// done. A grant is never revoked by a req change, only by done, by the
// watchdog or by reset. At least one IDLE cycle always separates two grants.
//
// All outputs come straight from flops. The FSM state is held in state_q.

module mux8_port_arbiter #(
  parameter int TO_WIDTH = 8,
  parameter int TO_LIMIT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // A watchdog limit that the counter cannot reach would never fire.
  if (TO_LIMIT < 1 || TO_LIMIT >= (1 << TO_WIDTH)) begin : g_to_limit_check
    $error("mux8_port_arbiter: TO_LIMIT must lie in 1 .. 2**TO_WIDTH-1");
  end

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [2:0] last_q, last_d;
  logic       timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] scan_idx;
  logic       wd_expire;

`ifdef ARB_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TO_LIMIT - 1);

  logic [TO_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

  // The counter holds the number of completed BUSY cycles; the last one
  // before the limit triggers the release.
  always_comb begin
    wd_expire = (state_q == ST_BUSY) && (wd_cnt_q == WD_LAST);
  end
`else
  // Without the watchdog a grant lasts until done.
  always_comb begin
    wd_expire = 1'b0;
  end
`endif

  // Rotating priority search starting just after the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    scan_idx  = last_q;
    for (int i = 1; i <= 8; i++) begin
      scan_idx = last_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    last_d    = last_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wd_cnt_d  = wd_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        grant_d = 8'h00;
        busy_d  = 1'b0;
        // sel keeps its last value so the mux output does not glitch.
        if (win_found) begin
          state_d = ST_BUSY;
          grant_d = 8'h01 << win_idx;
          sel_d   = win_idx;
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          wd_cnt_d = '0;
`endif
        end
      end
      ST_BUSY: begin
        // Release never grants on the same edge; the next winner is
        // picked in the following IDLE cycle with the updated pointer.
        if (done || wd_expire) begin
          state_d   = ST_IDLE;
          grant_d   = 8'h00;
          busy_d    = 1'b0;
          last_d    = sel_q;
          timeout_d = wd_expire && !done;
        end else begin
`ifdef ARB_TIMEOUT_EN
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 8'h00;
      sel_q     <= 3'd0;
      busy_q    <= 1'b0;
      last_q    <= 3'd7;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

`ifndef SYNTHESIS
  // Grant must be one-hot or zero at all times.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_q));

  // While busy, sel names exactly the granted requester.
  a_sel_matches: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q |-> (grant_q == (8'h01 << sel_q)));

  // busy and a non-zero grant always travel together.
  a_busy_grant: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (grant_q != 8'h00));
`endif

endmodule

// File: tb/tb_mux8_port_arbiter.sv
// Testbench for mux8_port_arbiter: directed scenarios followed by random
// transactions, with expected grant indices queued by the driver and
// popped by a monitor whenever a new grant appears.

module tb_mux8_port_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_LIM   = 4;
  localparam int HOLD_CAP = 2;
`else
  localparam int TO_LIM   = 200;
  localparam int HOLD_CAP = 12;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int         checks;
  int         errors;
  logic [2:0] exp_q[$];
  int         m_last;
  logic [7:0] held_grant;
  logic       prev_busy;

  mux8_port_arbiter #(
    .TO_WIDTH(8),
    .TO_LIMIT(TO_LIM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference rule: first requesting index after the last served one, mod 8.
  function automatic int model_pick(input logic [7:0] r, input int last);
    int idx;
    for (int k = 1; k <= 8; k++) begin
      idx = (last + k) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected winner each time a new grant appears.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual=%0h expected=none at %0t", grant, $time);
        end else begin
          e = exp_q.pop_front();
          chk("grant_onehot", 32'(grant), 32'h1 << e);
          chk("sel_index", 32'(sel), 32'(e));
        end
        held_grant = grant;
      end else if (busy) begin
        chk("grant_held", 32'(grant), 32'(held_grant));
      end else begin
        chk("idle_grant_zero", 32'(grant), 32'h0);
      end
`ifndef ARB_TIMEOUT_EN
      chk("timeout_tied", 32'(timeout), 32'h0);
`endif
      prev_busy = busy;
    end
  end

  // One transaction: request, hold for 'hold' extra cycles, then done.
  // req_mode 0 keeps req, 1 drops it, 2 scrambles it while busy.
  // Called just after a negedge with the DUT idle.
  task automatic do_txn(input logic [7:0] r, input int hold, input int req_mode);
    int w;
    w   = model_pick(r, m_last);
    req = r;
    exp_q.push_back(3'(w));
    @(negedge clk);
    chk("busy_after_req", 32'(busy), 32'h1);
    for (int h = 0; h < hold; h++) begin
      if (req_mode == 1) req = 8'h00;
      else if (req_mode == 2) req = 8'($urandom);
      @(negedge clk);
    end
    done = 1'b1;
    @(negedge clk);
    done   = 1'b0;
    req    = 8'h00;
    m_last = w;
    chk("release_busy", 32'(busy), 32'h0);
    chk("release_grant", 32'(grant), 32'h0);
    chk("sel_kept", 32'(sel), 32'(w));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 8'h00;
    done   = 1'b0;
    m_last = 7;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);

    // Full rotation from reset with everyone requesting, then wrap.
    req = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) do_txn(8'hFF, 0, 0);

    // Pointer at 5, then 0x24 wraps past 7 to index 2, then back to 5.
    do_txn(8'h20, 1, 0);
    do_txn(8'h24, 2, 0);
    do_txn(8'h24, 0, 0);

    // Requester 3 drops req while owning the resource.
    do_txn(8'h08, (HOLD_CAP < 10) ? HOLD_CAP : 10, 1);
    @(negedge clk);
    chk("sel_stable_idle", 32'(sel), 32'h3);
    chk("idle_busy", 32'(busy), 32'h0);

    // done in IDLE must not move the pointer.
    done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_done_busy", 32'(busy), 32'h0);
    end
    done = 1'b0;
    do_txn(8'hFF, 0, 0);

    // Reset in the middle of a grant to requester 4.
    rst_n = 1'b0;
    @(negedge clk);
    m_last = 7;
    rst_n  = 1'b1;
    req    = 8'h10;
    exp_q.push_back(3'(model_pick(8'h10, m_last)));
    @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    req = 8'h00;
    #1;
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_sel", 32'(sel), 32'h0);
    chk("abort_timeout", 32'(timeout), 32'h0);
    m_last = 7;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(8'h10, 1, 0);
    do_txn(8'h03, 0, 0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: requester 0 never gets done.
    req = 8'h01;
    exp_q.push_back(3'(model_pick(8'h01, m_last)));
    for (int k = 0; k < TO_LIM; k++) begin
      @(negedge clk);
      chk("wd_busy", 32'(busy), 32'h1);
      chk("wd_no_pulse", 32'(timeout), 32'h0);
    end
    m_last = 0;
    exp_q.push_back(3'(model_pick(8'h01, m_last)));
    @(negedge clk);
    chk("wd_pulse", 32'(timeout), 32'h1);
    chk("wd_release_busy", 32'(busy), 32'h0);
    chk("wd_release_grant", 32'(grant), 32'h0);
    @(negedge clk);
    chk("wd_regrant_busy", 32'(busy), 32'h1);
    chk("wd_pulse_once", 32'(timeout), 32'h0);
    req  = 8'h00;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("wd_done_busy", 32'(busy), 32'h0);

    // done on the same cycle the watchdog would fire: no pulse.
    req = 8'h02;
    exp_q.push_back(3'(model_pick(8'h02, m_last)));
    @(negedge clk);
    repeat (TO_LIM - 1) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done   = 1'b0;
    req    = 8'h00;
    m_last = 1;
    chk("wd_done_wins_pulse", 32'(timeout), 32'h0);
    chk("wd_done_wins_busy", 32'(busy), 32'h0);
`endif

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      do_txn(8'($urandom_range(1, 255)), $urandom_range(0, HOLD_CAP), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
